// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM state
// encoding and the default timing parameters (cycles at a 1 MHz clock).
package button_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } btn_state_e;

   localparam int DEF_NUM_BTN         = 3;
   localparam int DEF_DEBOUNCE_CYCLES = 10000;    // 10 ms
   localparam int DEF_HOLD_CYCLES     = 1000000;  // 1 s

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, debounce counter
// and long-press hold counter. All outputs are registered.
// Parameters must satisfy DEBOUNCE_CYCLES >= 2 and HOLD_CYCLES > DEBOUNCE_CYCLES.
module button_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
   input  logic clk,
   input  logic res,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel,
   output logic hold
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int HD_W = $clog2(HOLD_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

   logic            sync1_q;
   logic            s_q;
   btn_state_e      state_q,    state_d;
   logic [DB_W-1:0] db_cnt_q,   db_cnt_d;
   logic [HD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic            hold_done_q, hold_done_d;
   logic            level_q,    level_d;
   logic            press_q,    press_d;
   logic            rel_q,      rel_d;
   logic            hold_q,     hold_d;

   // Two-stage synchronizer for the asynchronous raw button level
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
      end else begin
         sync1_q <= raw;
         s_q     <= sync1_q;
      end
   end

   // Next-state, counter and event logic; pulses default low every cycle
   always_comb begin
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      hold_done_d = hold_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      hold_d      = 1'b0;
      case (state_q)
         ST_RELEASED: begin
            if (s_q) begin
               state_d  = ST_PRESS_WAIT;
               db_cnt_d = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!s_q) begin
               state_d = ST_RELEASED;
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = ST_PRESSED;
               level_d     = 1'b1;
               press_d     = 1'b1;
               hold_cnt_d  = '0;
               hold_done_d = 1'b0;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         ST_PRESSED: begin
            // Hold counter saturates at its last value; hold_done keeps the
            // long-press event to a single pulse per accepted press.
            if (hold_cnt_q != HD_LAST) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
            if (hold_cnt_q == HD_LAST && !hold_done_q) begin
               hold_d      = 1'b1;
               hold_done_d = 1'b1;
            end
            if (!s_q) begin
               state_d  = ST_RELEASE_WAIT;
               db_cnt_d = '0;
            end
         end
         ST_RELEASE_WAIT: begin
            // Hold counter is frozen here so a short glitch only delays it
            if (s_q) begin
               state_d = ST_PRESSED;
            end else if (db_cnt_q == DB_LAST) begin
               state_d = ST_RELEASED;
               level_d = 1'b0;
               rel_d   = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_RELEASED;
         end
      endcase
   end

   // State, counter and output registers
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q     <= ST_RELEASED;
         db_cnt_q    <= '0;
         hold_cnt_q  <= '0;
         hold_done_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         rel_q       <= 1'b0;
         hold_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         hold_done_q <= hold_done_d;
         level_q     <= level_d;
         press_q     <= press_d;
         rel_q       <= rel_d;
         hold_q      <= hold_d;
      end
   end

   assign level = level_q;
   assign press = press_q;
   assign rel   = rel_q;
   assign hold  = hold_q;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner top: NUM_BTN independent debounce channels
// (bit 0 start_stop, bit 1 lap_time, bit 2 clear).
module button_conditioner
   import button_pkg::*;
#(
   parameter int NUM_BTN         = DEF_NUM_BTN,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
   input  logic               clk,
   input  logic               res,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_hold
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES)
      ) u_ch (
         .clk   (clk),
         .res   (res),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .press (btn_press[i]),
         .rel   (btn_release[i]),
         .hold  (btn_hold[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
// Expected pulse events (cycle, channel, kind) are queued when stimulus is
// driven; a negedge monitor pops the matching entry for every pulse seen.
module tb_button_conditioner;

   localparam int NB = 3;
   localparam int DB = 4;
   localparam int HD = 20;
   localparam int LAT = DB + 2;  // edges from first sample (edge 1) to event edge

   logic          clk = 1'b0;
   logic          res = 1'b1;
   logic [NB-1:0] btn_raw = '0;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic [NB-1:0] btn_hold;

   button_conditioner #(
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (DB),
      .HOLD_CYCLES     (HD)
   ) dut (
      .clk         (clk),
      .res         (res),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_hold    (btn_hold)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int ch;
      int kind;  // 0 press, 1 release, 2 hold
   } ev_t;

   ev_t   exp_q[$];
   int    n_chk  = 0;
   int    n_pass = 0;
   string kname[3] = '{"press", "release", "hold"};

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic expect_ev(input int c, input int ch, input int kind);
      ev_t e;
      e.cyc  = c;
      e.ch   = ch;
      e.kind = kind;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Pulse monitor: every observed pulse must match a queued expectation
   always @(negedge clk) begin : mon
      logic p;
      int   idx;
      if (!res) begin
         for (int ch = 0; ch < NB; ch++) begin
            for (int k = 0; k < 3; k++) begin
               p = (k == 0) ? btn_press[ch] : (k == 1) ? btn_release[ch] : btn_hold[ch];
               if (p) begin
                  idx = -1;
                  foreach (exp_q[i])
                     if (idx < 0 && exp_q[i].ch == ch && exp_q[i].kind == k) idx = i;
                  if (idx >= 0) begin
                     chk($sformatf("%s_ch%0d_cycle", kname[k], ch), cyc, exp_q[idx].cyc);
                     exp_q.delete(idx);
                  end else begin
                     chk($sformatf("unexpected_%s_ch%0d_at_cycle", kname[k], ch), cyc, -1);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int f, g, l;

   initial begin
      // Reset state
      res     = 1'b1;
      btn_raw = '0;
      repeat (3) @(negedge clk);
      chk("reset_level",   int'(btn_level),   0);
      chk("reset_press",   int'(btn_press),   0);
      chk("reset_release", int'(btn_release), 0);
      chk("reset_hold",    int'(btn_hold),    0);
      res = 1'b0;
      repeat (2) @(negedge clk);

      // A: btn 0 high for 12 samples -> press at edge 7, no hold
      btn_raw[0] = 1'b1;
      f = cyc + 1;
      expect_ev(f + LAT, 0, 0);
      wait_cyc(f + LAT);
      chk("A_level_on", int'(btn_level[0]), 1);
      chk("A_press_vec", int'(btn_press), 1);
      wait_cyc(f + 11);
      btn_raw[0] = 1'b0;
      l = f + 12;
      expect_ev(l + LAT, 0, 1);
      wait_cyc(l + LAT + 2);
      chk("A_level_off", int'(btn_level[0]), 0);

      // B: btn 1 bouncing 3 high / 1 low -> never accepted
      for (int i = 0; i < 10; i++) begin
         btn_raw[1] = 1'b1;
         repeat (3) @(negedge clk);
         btn_raw[1] = 1'b0;
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      chk("B_level", int'(btn_level[1]), 0);

      // C: btn 2 held 40 samples -> press 7, hold 27, release 7 after low
      btn_raw[2] = 1'b1;
      f = cyc + 1;
      expect_ev(f + LAT, 2, 0);
      expect_ev(f + LAT + HD, 2, 2);
      wait_cyc(f + 30);
      chk("C_level_on", int'(btn_level[2]), 1);
      wait_cyc(f + 39);
      btn_raw[2] = 1'b0;
      l = f + 40;
      expect_ev(l + LAT, 2, 1);
      wait_cyc(l + LAT + 2);
      chk("C_level_off", int'(btn_level[2]), 0);

      // D: 2-cycle low glitch while pressed -> hold delayed by 2 cycles only
      btn_raw[0] = 1'b1;
      f = cyc + 1;
      expect_ev(f + LAT, 0, 0);
      expect_ev(f + LAT + HD + 2, 0, 2);
      wait_cyc(f + 9);
      btn_raw[0] = 1'b0;
      wait_cyc(f + 11);
      btn_raw[0] = 1'b1;
      wait_cyc(f + 16);
      chk("D_level_glitch", int'(btn_level[0]), 1);
      wait_cyc(f + 39);
      btn_raw[0] = 1'b0;
      l = f + 40;
      expect_ev(l + LAT, 0, 1);
      wait_cyc(l + LAT + 2);
      chk("D_level_off", int'(btn_level[0]), 0);

      // E: all buttons on the same edge -> simultaneous pulses
      btn_raw = 3'b111;
      f = cyc + 1;
      for (int ch = 0; ch < NB; ch++) expect_ev(f + LAT, ch, 0);
      wait_cyc(f + LAT);
      chk("E_press_all", int'(btn_press), 7);
      wait_cyc(f + 11);
      btn_raw = 3'b000;
      l = f + 12;
      for (int ch = 0; ch < NB; ch++) expect_ev(l + LAT, ch, 1);
      wait_cyc(l + LAT);
      chk("E_release_all", int'(btn_release), 7);
      wait_cyc(l + LAT + 2);
      chk("E_level_off", int'(btn_level), 0);

      // F: reset with btn 1 pressed and btn 0 mid-debounce
      btn_raw[1] = 1'b1;
      f = cyc + 1;
      expect_ev(f + LAT, 1, 0);
      wait_cyc(f + 8);
      btn_raw[0] = 1'b1;
      g = cyc + 1;
      wait_cyc(g + 3);
      #2 res = 1'b1;
      #1;
      chk("F_async_level", int'(btn_level), 0);
      chk("F_async_press", int'(btn_press), 0);
      @(negedge clk);
      @(negedge clk);
      res = 1'b0;
      f = cyc + 1;
      expect_ev(f + LAT, 0, 0);
      expect_ev(f + LAT, 1, 0);
      wait_cyc(f + LAT - 1);
      chk("F_no_early_press", int'(btn_press), 0);
      wait_cyc(f + LAT);
      chk("F_press_after_reset", int'(btn_press), 3);
      wait_cyc(f + 11);
      btn_raw = 3'b000;
      l = f + 12;
      expect_ev(l + LAT, 0, 1);
      expect_ev(l + LAT, 1, 1);
      wait_cyc(l + LAT + 4);

      // Every queued expectation must have been consumed
      foreach (exp_q[i])
         chk($sformatf("missing_%s_ch%0d", kname[exp_q[i].kind], exp_q[i].ch), -1, exp_q[i].cyc);
      chk("pending_events", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter NUM_BTN, default 3, number of independent button channels (bit 0 start_stop, bit 1 lap_time, bit 2 clear).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 10000, stable-input cycles needed to accept a level change (10 ms at 1 MHz).
REQ-003 SHALL have parameter HOLD_CYCLES, default 1000000, cycles in the pressed state before a long-press event (1 s at 1 MHz).
REQ-004 SHALL have port clk, input, 1, system clock (1 MHz).
REQ-005 SHALL have port res, input, 1; one clock, reset asynchronous and active-high.
REQ-006 SHALL have port btn_raw, input, NUM_BTN, asynchronous bouncing button levels, 1 = pressed.
REQ-007 SHALL have port btn_level, output, NUM_BTN, debounced button level.
REQ-008 SHALL have port btn_press, output, NUM_BTN, one-cycle pulse on accepted press.
REQ-009 SHALL have port btn_release, output, NUM_BTN, one-cycle pulse on accepted release.
REQ-010 SHALL have port btn_hold, output, NUM_BTN, one-cycle pulse, at most once per press, on long press.

Function
REQ-011 SHALL pass each btn_raw bit through a 2-flop synchronizer; its output is called s.
REQ-012 SHALL run per channel an FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, a debounce counter (clog2(DEBOUNCE_CYCLES) bits) and a hold counter (clog2(HOLD_CYCLES) bits).
REQ-013 RELEASED: s=1 -> PRESS_WAIT, debounce counter cleared to 0; otherwise stay.
REQ-014 PRESS_WAIT: s=0 -> RELEASED with no output event; s=1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED; else counter +1.
REQ-015 On PRESS_WAIT->PRESSED, btn_press SHALL be high for exactly the cycle following that edge, btn_level SHALL go 1 at the same edge, hold counter cleared to 0.
REQ-016 Press latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges from the first edge sampling btn_raw high (2 sync + 1 entry + DEBOUNCE_CYCLES count).
REQ-017 PRESSED: hold counter +1 per cycle, saturating; when it equals HOLD_CYCLES-1, btn_hold pulses one cycle (HOLD_CYCLES edges after btn_press) and SHALL NOT pulse again until a new press.
REQ-018 PRESSED: s=0 -> RELEASE_WAIT, debounce counter cleared to 0.
REQ-019 RELEASE_WAIT: s=1 -> PRESSED without press pulse, hold counter retained (frozen while in RELEASE_WAIT); s=0 and counter = DEBOUNCE_CYCLES-1 -> RELEASED, btn_level 0, btn_release one-cycle pulse; else counter +1.
REQ-020 Channels SHALL be fully independent; simultaneous accepted presses SHALL give pulses in the same cycle.
REQ-021 All outputs SHALL be registered; no combinational path from btn_raw to any output.
REQ-022 Parameters SHALL satisfy DEBOUNCE_CYCLES >= 2 and HOLD_CYCLES > DEBOUNCE_CYCLES.

Reset
REQ-023 res high SHALL immediately force synchronizer flops 0, all FSMs RELEASED, all counters 0, all outputs 0, regardless of clk.
REQ-024 Reset mid-debounce SHALL discard the pending event; no pulse after reset release.
REQ-025 A button held across reset release SHALL be treated as a new press (btn_press after DEBOUNCE_CYCLES+3 edges).

Structure
REQ-026 FSM state encoding and default parameter values SHALL live in a shared package button_pkg.
REQ-027 One channel (synchronizer, FSM, both counters) SHALL be sub-module button_channel, instantiated NUM_BTN times.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20)
REQ-028 btn_raw[0] high 12 cycles -> btn_press[0] single pulse 7 edges after first sample; btn_level[0]=1; no btn_hold.
REQ-029 btn_raw[1] toggling 3 high / 1 low for 40 cycles -> btn_press, btn_level, btn_release stay 0.
REQ-030 btn_raw[2] held 40 cycles -> btn_press at edge 7, btn_hold once at edge 27; release -> btn_release 7 edges after first low sample.
REQ-031 In PRESSED, 2-cycle low glitch -> no release, no second press, btn_hold timing shifted by the frozen cycles only.
REQ-032 All three buttons raised on same edge -> btn_press = 3'b111 for one cycle.
REQ-033 res pulsed while channel 0 in PRESS_WAIT (raw held) -> outputs 0 at once; after release, btn_press[0] at edge 7 counted from first post-reset sample.
